ad7608_emulator: RTL

Cycle-based model of the AD7608 serial readout that runs in a single clock domain. It answers `adc_controller`: it takes CONVST, nCS, SCLK and RESET in, and drives BUSY and the two DOUT lines. Loopback self-test and bench builds swap it in for the physical ADC, so the PID pipeline can be exercised end-to-end with known channel values. The host loads those per-channel values through a simple write port.

---
 rtl/ad7608_emulator.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ad7608_emulator.sv
// ad7608_emulator: cycle-based AD7608 serial readout model; define ADC_EMU_SYNC_EN for 2-flop pin synchronizers (L=3).
module ad7608_emulator #(
  parameter int W_DATA = 18,
  parameter int N_CHAN = 8,
  parameter int W_CHAN = 3,
  parameter int W_OS   = 3,
  parameter int T_CONV = 200
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_OS-1:0]   os_in,
  input  logic              convst_in,
  input  logic              adc_reset_in,
  input  logic              n_cs_in,
  input  logic              sclk_in,
  input  logic              ld_en_in,
  input  logic [W_CHAN-1:0] ld_chan_in,
  input  logic [W_DATA-1:0] ld_data_in,
  output logic              busy_out,
  output logic              data_a_out,
  output logic              data_b_out,
  output logic              frame_done_out,
  output logic              err_out
);
  localparam int N_HALF = N_CHAN / 2;
  localparam int W_WORD = $clog2(N_HALF);
  localparam int W_BIT  = $clog2(W_DATA);
  localparam int W_CNT  = $clog2(T_CONV) + (1 << W_OS);
`ifdef ADC_EMU_SYNC_EN
  localparam int N_STG = 3;
`else
  localparam int N_STG = 1;
`endif
  typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;
  state_t state, state_n;
  logic [N_STG:0] convst_q, ncs_q, sclk_q;
  logic [W_DATA-1:0] chan [N_CHAN];
  logic [W_DATA-1:0] snap [N_CHAN];
  logic [W_CNT-1:0] cnt, cnt_n;
  logic [W_WORD-1:0] word, word_n, w_nxt;
  logic [W_BIT-1:0] bit_i, bit_n, b_nxt;
  logic busy_n, da_n, db_n, done_n, err_n, take;
  logic convst_rise, ncs_fall, ncs_rise, sclk_fall, os_bad, last;
  logic [W_OS-1:0] os_eff;
  // top bit of each pipe is the previous sample, the one below it the current one
  assign convst_rise = convst_q[N_STG-1] & ~convst_q[N_STG];
  assign ncs_fall    = ~ncs_q[N_STG-1] & ncs_q[N_STG];
  assign ncs_rise    = ncs_q[N_STG-1] & ~ncs_q[N_STG];
  assign sclk_fall   = ~sclk_q[N_STG-1] & sclk_q[N_STG] & ~ncs_q[N_STG-1];
  assign os_bad      = &os_in;
  assign os_eff      = os_bad ? '0 : os_in;
  assign last        = bit_i == '0;
  assign w_nxt       = last ? word + W_WORD'(1) : word;
  assign b_nxt       = last ? W_BIT'(W_DATA-1) : bit_i - W_BIT'(1);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    bit_n   = bit_i;
    busy_n  = busy_out;
    da_n    = data_a_out;
    db_n    = data_b_out;
    done_n  = 1'b0;
    err_n   = err_out;
    take    = 1'b0;
    if (adc_reset_in) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      da_n    = 1'b0;
      db_n    = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (convst_rise) begin
            take    = 1'b1;
            cnt_n   = W_CNT'(T_CONV) << os_eff;
            busy_n  = 1'b1;
            da_n    = 1'b0;
            db_n    = 1'b0;
            err_n   = err_out | os_bad;
            state_n = CONVERT;
          end else if (state == READY && ncs_fall) begin
            word_n  = '0;
            bit_n   = W_BIT'(W_DATA-1);
            da_n    = snap[0][W_DATA-1];
            db_n    = snap[N_HALF][W_DATA-1];
            state_n = SHIFT;
          end
        end
        CONVERT: begin
          err_n = err_out | convst_rise;
          cnt_n = cnt - W_CNT'(1);
          if (cnt == W_CNT'(1)) begin
            busy_n  = 1'b0;
            state_n = READY;
          end
        end
        SHIFT: begin
          err_n = err_out | convst_rise;
          if (ncs_rise) begin
            da_n    = 1'b0;
            db_n    = 1'b0;
            state_n = IDLE;
          end else if (sclk_fall) begin
            word_n = w_nxt;
            bit_n  = b_nxt;
            da_n   = snap[W_CHAN'(w_nxt)][b_nxt];
            db_n   = snap[W_CHAN'(N_HALF) + W_CHAN'(w_nxt)][b_nxt];
            if (last && word == W_WORD'(N_HALF-1)) begin
              da_n    = 1'b0;
              db_n    = 1'b0;
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state          <= IDLE;
      convst_q       <= '0;
      ncs_q          <= '1;
      sclk_q         <= '0;
      cnt            <= '0;
      word           <= '0;
      bit_i          <= '0;
      busy_out       <= 1'b0;
      data_a_out     <= 1'b0;
      data_b_out     <= 1'b0;
      frame_done_out <= 1'b0;
      err_out        <= 1'b0;
      for (int i = 0; i < N_CHAN; i++) begin
        chan[i] <= '0;
        snap[i] <= '0;
      end
    end else begin
      state          <= state_n;
      convst_q       <= {convst_q[N_STG-1:0], convst_in};
      ncs_q          <= {ncs_q[N_STG-1:0], n_cs_in};
      sclk_q         <= {sclk_q[N_STG-1:0], sclk_in};
      cnt            <= cnt_n;
      word           <= word_n;
      bit_i          <= bit_n;
      busy_out       <= busy_n;
      data_a_out     <= da_n;
      data_b_out     <= db_n;
      frame_done_out <= done_n;
      err_out        <= err_n;
      if (ld_en_in) chan[ld_chan_in] <= ld_data_in;
      // snapshot reads pre-write contents, so a same-cycle load lands in the next conversion
      if (take) snap <= chan;
    end
  end
endmodule
